// File: rtl/noc_pkg.sv
// Shared definitions for the XY mesh router: port indices, select width
// and helpers locating the destination coordinate fields inside a flit.
package noc_pkg;

  // Width of every crossbar select / port index.
  localparam int N_WIDTH = 3;

  typedef logic [N_WIDTH-1:0] port_sel_t;

  // Port indices of the five-port switch.
  localparam port_sel_t LOCAL = 3'd0;
  localparam port_sel_t WEST  = 3'd1;
  localparam port_sel_t EAST  = 3'd2;
  localparam port_sel_t NORTH = 3'd3;
  localparam port_sel_t SOUTH = 3'd4;

  // Destination X occupies the top COORD_WIDTH bits of the flit.
  function automatic int dest_x_msb(input int data_width);
    return data_width - 1;
  endfunction

  // Destination Y occupies the COORD_WIDTH bits directly below X.
  function automatic int dest_y_msb(input int data_width, input int coord_width);
    return data_width - 1 - coord_width;
  endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Dimension-ordered (X first, then Y) output port selection for one head
// flit. Purely combinational; one instance per switch input.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int COORD_WIDTH = 2,
  parameter int X_COORD     = 0,
  parameter int Y_COORD     = 0
) (
  input  logic [COORD_WIDTH-1:0] i_dest_x,
  input  logic [COORD_WIDTH-1:0] i_dest_y,
  output port_sel_t              o_route
);

  localparam logic [COORD_WIDTH-1:0] LP_X = COORD_WIDTH'(X_COORD);
  localparam logic [COORD_WIDTH-1:0] LP_Y = COORD_WIDTH'(Y_COORD);

  // Resolve X fully before moving in Y; equal in both means deliver locally.
  always_comb begin
    o_route = LOCAL;
    if (i_dest_x > LP_X) begin
      o_route = EAST;
    end else if (i_dest_x < LP_X) begin
      o_route = WEST;
    end else if (i_dest_y > LP_Y) begin
      o_route = SOUTH;
    end else if (i_dest_y < LP_Y) begin
      o_route = NORTH;
    end
  end

endmodule

// File: rtl/xy_switch_ctrl.sv
// Switch controller for an XY mesh router: computes a route per input,
// grants one input per cycle round-robin, drives the crossbar selects and
// FIFO pop strobe, and keeps one valid bit per output.
//
// Output handshake: out_vld_o[o] rises on the edge ending a grant to output
// o and stays high until an edge where out_rdy_i[o] is also high, on which
// it falls. An output is only grantable while its valid bit is low, so a
// grant never depends on out_rdy_i and a clearing output is grantable only
// from the following cycle.
module xy_switch_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PORT_N      = 5,
  parameter int X_COORD     = 0,
  parameter int Y_COORD     = 0,
  parameter int COORD_WIDTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [PORT_N*DATA_WIDTH-1:0] head_data_i,
  input  logic [PORT_N-1:0]            fifo_empty_i,
  input  logic [PORT_N-1:0]            out_rdy_i,
  output logic [PORT_N-1:0]            fifo_rd_o,
  output logic [N_WIDTH-1:0]           mux_in_sel_o,
  output logic [N_WIDTH-1:0]           mux_out_sel_o,
  output logic [PORT_N-1:0]            out_vld_o
);

  localparam int LP_X_MSB = dest_x_msb(DATA_WIDTH);
  localparam int LP_Y_MSB = dest_y_msb(DATA_WIDTH, COORD_WIDTH);

  // Registered state
  logic [PORT_N-1:0] r_out_vld;
  port_sel_t         r_rr_ptr;
  port_sel_t         r_mux_in_hold;
  port_sel_t         r_mux_out_hold;

  // Combinational nets
  port_sel_t         w_route [PORT_N];
  logic [PORT_N-1:0] w_elig;
  logic              w_gnt_vld;
  logic              w_gnt_act;
  port_sel_t         w_gnt_idx;
  port_sel_t         w_gnt_route;
  logic [PORT_N-1:0] w_set;
  logic [PORT_N-1:0] w_clr;
  logic              w_unused_data;

  // Only the coordinate fields steer routing; payload bits go straight to
  // the crossbar.
  assign w_unused_data = ^head_data_i;

  // Index base+offs wrapped into 0..PORT_N-1 (offs < PORT_N).
  function automatic port_sel_t wrap_idx(input port_sel_t base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= PORT_N) s = s - PORT_N;
    return port_sel_t'(s);
  endfunction

  // One route calculator per input, fed with the head flit's coordinates.
  for (genvar p = 0; p < PORT_N; p++) begin : g_route
    xy_route_calc #(
      .COORD_WIDTH (COORD_WIDTH),
      .X_COORD     (X_COORD),
      .Y_COORD     (Y_COORD)
    ) u_route (
      .i_dest_x (head_data_i[DATA_WIDTH*p + LP_X_MSB -: COORD_WIDTH]),
      .i_dest_y (head_data_i[DATA_WIDTH*p + LP_Y_MSB -: COORD_WIDTH]),
      .o_route  (w_route[p])
    );
  end

  // An input may compete when it has a flit and its target output is idle.
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < PORT_N; p++) begin
      w_elig[p] = !fifo_empty_i[p] && !r_out_vld[w_route[p]];
    end
  end

  // Round-robin search starting at the pointer; first eligible input wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < PORT_N; i++) begin
      if (!w_gnt_vld && w_elig[wrap_idx(r_rr_ptr, i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = wrap_idx(r_rr_ptr, i);
      end
    end
  end

  // No grant is acted on while reset is held, so no flit is popped.
  assign w_gnt_act   = w_gnt_vld && rst_ni;
  assign w_gnt_route = w_route[w_gnt_idx];

  // Selects follow the live grant, otherwise show the last granted pair.
  assign mux_in_sel_o  = w_gnt_act ? w_gnt_idx   : r_mux_in_hold;
  assign mux_out_sel_o = w_gnt_act ? w_gnt_route : r_mux_out_hold;

  // One-hot pop strobe and valid-set vector decoded from the grant.
  always_comb begin
    fifo_rd_o = '0;
    w_set     = '0;
    for (int p = 0; p < PORT_N; p++) begin
      fifo_rd_o[p] = w_gnt_act && (w_gnt_idx == port_sel_t'(p));
      w_set[p]     = w_gnt_act && (w_gnt_route == port_sel_t'(p));
    end
  end

  assign w_clr = r_out_vld & out_rdy_i;

  // Per-output valid: set by a grant, cleared by downstream acceptance.
  // Set and clear never meet on one bit because a busy output is ineligible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_vld <= '0;
    end else begin
      r_out_vld <= (r_out_vld & ~w_clr) | w_set;
    end
  end

  // Pointer advances past the winner; selects remember the last grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr       <= '0;
      r_mux_in_hold  <= '0;
      r_mux_out_hold <= '0;
    end else if (w_gnt_act) begin
      r_rr_ptr       <= wrap_idx(w_gnt_idx, 1);
      r_mux_in_hold  <= w_gnt_idx;
      r_mux_out_hold <= w_gnt_route;
    end
  end

  assign out_vld_o = r_out_vld;

endmodule

// File: tb/tb_xy_switch_ctrl.sv
// Directed bench for xy_switch_ctrl at router (1,1). Expected grants are
// queued by the driver and checked by a monitor whenever a pop strobe shows.
module tb_xy_switch_ctrl;

  localparam int DW = 8;
  localparam int PN = 5;
  localparam int NW = 3;
  localparam int EW = PN + 2 * NW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PN*DW-1:0] head_data;
  logic [PN-1:0]    fifo_empty;
  logic [PN-1:0]    out_rdy;
  logic [PN-1:0]    fifo_rd;
  logic [NW-1:0]    mux_in;
  logic [NW-1:0]    mux_out;
  logic [PN-1:0]    out_vld;

  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    mon_exp;
  logic [PN-1:0]    rd_s;
  int               checks = 0;
  int               errors = 0;

  xy_switch_ctrl #(
    .DATA_WIDTH  (DW),
    .PORT_N      (PN),
    .X_COORD     (1),
    .Y_COORD     (1),
    .COORD_WIDTH (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .head_data_i   (head_data),
    .fifo_empty_i  (fifo_empty),
    .out_rdy_i     (out_rdy),
    .fifo_rd_o     (fifo_rd),
    .mux_in_sel_o  (mux_in),
    .mux_out_sel_o (mux_out),
    .out_vld_o     (out_vld)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic load(input int p, input logic [DW-1:0] f);
    head_data[p*DW +: DW] = f;
    fifo_empty[p] = 1'b0;
  endtask

  task automatic expect_grant(input int p, input logic [NW-1:0] route);
    logic [PN-1:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    exp_q.push_back({oh, NW'(p), route});
  endtask

  // One cycle; FIFOs popped on the edge empty themselves (single-flit model).
  task automatic tick();
    @(negedge clk);
    rd_s = fifo_rd;
    @(posedge clk);
    #1;
    for (int p = 0; p < PN; p++) begin
      if (rd_s[p]) fifo_empty[p] = 1'b1;
    end
  endtask

  task automatic check_vec(input string name, input logic [PN-1:0] act, input logic [PN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_sel(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every visible grant must match the queue head.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (fifo_rd != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got rd=%b in=%0d out=%0d expected no grant",
                   fifo_rd, mux_in, mux_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({fifo_rd, mux_in, mux_out} !== mon_exp) begin
            errors++;
            $display("FAIL grant: got rd=%b in=%0d out=%0d expected rd=%b in=%0d out=%0d",
                     fifo_rd, mux_in, mux_out,
                     mon_exp[EW-1 -: PN], mon_exp[2*NW-1 -: NW], mon_exp[NW-1:0]);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    fifo_empty = '1;
    out_rdy    = '0;
    head_data  = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_vld", out_vld, 5'b00000);
    check_vec("rst_rd", fifo_rd, 5'b00000);
    check_sel("rst_in_sel", mux_in, 3'd0);
    check_sel("rst_out_sel", mux_out, 3'd0);
    rst_n = 1'b1;

    // Local head to (3,0) goes East, valid one cycle later.
    load(0, 8'hC0);
    expect_grant(0, 3'd2);
    tick();
    check_vec("a_vld", out_vld, 5'b00100);
    check_sel("a_hold_in", mux_in, 3'd0);
    check_sel("a_hold_out", mux_out, 3'd2);
    tick();
    check_vec("a_vld_held", out_vld, 5'b00100);
    out_rdy[2] = 1'b1;
    tick();
    check_vec("a_vld_clr", out_vld, 5'b00000);

    // Local delivery blocks a second flit until one cycle after ready.
    out_rdy = '0;
    load(1, 8'h50);
    expect_grant(1, 3'd0);
    tick();
    check_vec("b_vld", out_vld, 5'b00001);
    load(2, 8'h50);
    tick();
    tick();
    check_vec("b_blocked_vld", out_vld, 5'b00001);
    check_vec("b_blocked_rd", fifo_rd, 5'b00000);
    out_rdy[0] = 1'b1;
    #1;
    check_vec("b_clear_cycle_rd", fifo_rd, 5'b00000);
    tick();
    check_vec("b_cleared", out_vld, 5'b00000);
    expect_grant(2, 3'd0);
    tick();
    check_vec("b_second_vld", out_vld, 5'b00001);
    tick();
    check_vec("b_second_clr", out_vld, 5'b00000);
    check_sel("b_hold_in", mux_in, 3'd2);
    check_sel("b_hold_out", mux_out, 3'd0);

    // Distinct outputs granted back to back (pointer sits at 3).
    out_rdy = '0;
    load(3, 8'hC0);
    load(4, 8'h40);
    expect_grant(3, 3'd2);
    expect_grant(4, 3'd3);
    tick();
    check_vec("e_vld1", out_vld, 5'b00100);
    tick();
    check_vec("e_vld2", out_vld, 5'b01100);

    // Build 00110, then reset asynchronously mid-cycle.
    out_rdy = '1;
    tick();
    check_vec("d_drain", out_vld, 5'b00000);
    out_rdy = '0;
    load(0, 8'h00);
    load(1, 8'hC0);
    expect_grant(0, 3'd1);
    expect_grant(1, 3'd2);
    tick();
    tick();
    check_vec("d_vld_pre", out_vld, 5'b00110);
    load(2, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("d_rst_vld", out_vld, 5'b00000);
    check_vec("d_rst_rd", fifo_rd, 5'b00000);
    check_sel("d_rst_in", mux_in, 3'd0);
    check_sel("d_rst_out", mux_out, 3'd0);
    load(0, 8'h00);
    load(3, 8'h00);
    out_rdy = '1;
    tick();
    tick();
    check_vec("d_rst_hold_vld", out_vld, 5'b00000);
    rst_n = 1'b1;

    // Three inputs contend for West; pointer restarts at input 0.
    expect_grant(0, 3'd1);
    tick();
    check_vec("c_vld_0", out_vld, 5'b00010);
    tick();
    check_vec("c_clr_0", out_vld, 5'b00000);
    expect_grant(2, 3'd1);
    tick();
    check_vec("c_vld_2", out_vld, 5'b00010);
    tick();
    check_vec("c_clr_2", out_vld, 5'b00000);
    expect_grant(3, 3'd1);
    tick();
    check_vec("c_vld_3", out_vld, 5'b00010);
    tick();
    check_vec("c_clr_3", out_vld, 5'b00000);
    tick();

    // Final report
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_grants: got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
